// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: EX/MEM and MEM/WB buffer words, memory-stage
// FSM states, load/store funct3 encodings and byte-lane mask helpers.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
    } ctrl_word_t;

    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] insn;
        logic [31:0] rvfi_mem_addr;
        logic [3:0]  rvfi_mem_rmask;
        logic [3:0]  rvfi_mem_wmask;
        logic [31:0] rvfi_mem_rdata;
        logic [31:0] rvfi_mem_wdata;
    } rvfi_data_t;

    typedef struct packed {
        ctrl_word_t  ctrl_wd;
        logic [31:0] mar;
        logic [31:0] mem_data_out;
        logic [31:0] alu_out;
        logic        cmp_out;
        logic [31:0] u_imm;
        logic [4:0]  rd;
        rvfi_data_t  rvfi_d;
    } EX_MEM_stage_t;

    typedef struct packed {
        ctrl_word_t  ctrl_wd;
        logic [31:0] alu_out;
        logic        cmp_out;
        logic [31:0] u_imm;
        logic [4:0]  rd;
        logic [31:0] mdr;
        rvfi_data_t  rvfi_d;
    } MEM_WB_stage_t;

    // Byte enables for a store; a halfword at offset 3 keeps only lane 3.
    function automatic logic [3:0] store_wmask(input logic [2:0] funct3,
                                               input logic [1:0] off);
        logic [3:0] mask;
        case (store_funct3_t'(funct3))
            sb:      mask = 4'b0001 << off;
            sh:      mask = 4'b0011 << off;
            sw:      mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Byte lanes a load actually consumes.
    function automatic logic [3:0] load_rmask(input logic [2:0] funct3,
                                              input logic [1:0] off);
        logic [3:0] mask;
        case (load_funct3_t'(funct3))
            lb, lbu: mask = 4'b0001 << off;
            lh, lhu: mask = 4'b0011 << off;
            lw:      mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: shifts the cache word down by the byte offset and
// sign- or zero-extends according to the load funct3.
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] mdr
);

    logic [31:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    // Select and extend the addressed byte/halfword; words are never shifted.
    always_comb begin
        mdr = rdata;
        case (load_funct3_t'(funct3))
            lb:      mdr = {{24{shifted[7]}}, shifted[7:0]};
            lbu:     mdr = {24'h000000, shifted[7:0]};
            lh:      mdr = {{16{shifted[15]}}, shifted[15:0]};
            lhu:     mdr = {16'h0000, shifted[15:0]};
            lw:      mdr = rdata;
            default: mdr = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: issues the data-cache handshake,
// stalls upstream until the response, aligns load data and registers the
// MEM/WB buffer. Optional RVFI memory-field capture is enabled with the
// MEM_STAGE_RVFI_EN macro.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no outstanding request, or a request answered in its first cycle
// WAIT  | request issued, waiting for dmem_resp; upstream frozen
module mem_stage
    import rv32i_types::*;
#(
    parameter int unsigned MAX_WAIT   = 0,
    parameter int unsigned WAIT_CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  EX_MEM_stage_t ex_mem_in,
    input  logic          in_valid,
    output logic [31:0]   dmem_address,
    output logic          dmem_read,
    output logic          dmem_write,
    output logic [3:0]    dmem_wmask,
    output logic [31:0]   dmem_wdata,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_resp,
    output logic          mem_stall,
    output MEM_WB_stage_t mem_wb_out,
    output logic          out_valid,
    output logic          mem_timeout
);

    localparam logic [WAIT_CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    mem_state_t            state;
    mem_state_t            state_next;
    logic                  req;
    logic [1:0]            off;
    logic [31:0]           mdr_aligned;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] cnt_inc;
    logic                  stay_wait;

    assign off = ex_mem_in.mar[1:0];
    assign req = in_valid & (ex_mem_in.ctrl_wd.mem_read | ex_mem_in.ctrl_wd.mem_write);

    // Reset drops the request in the same cycle so an abandoned access ends at once.
    assign dmem_read    = ~rst & in_valid & ex_mem_in.ctrl_wd.mem_read;
    assign dmem_write   = ~rst & in_valid & ex_mem_in.ctrl_wd.mem_write;
    assign dmem_address = {ex_mem_in.mar[31:2], 2'b00};
    assign dmem_wmask   = ex_mem_in.ctrl_wd.mem_write
                        ? store_wmask(ex_mem_in.ctrl_wd.funct3, off) : 4'b0000;
    assign dmem_wdata   = ex_mem_in.mem_data_out;
    assign mem_stall    = req & ~dmem_resp;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .off    (off),
        .funct3 (ex_mem_in.ctrl_wd.funct3),
        .mdr    (mdr_aligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: park in WAIT only while a request is outstanding and unanswered.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req && !dmem_resp) state_next = WAIT;
            WAIT:    if (!req || dmem_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stay_wait = (state == WAIT) && (state_next == WAIT);
    assign cnt_inc   = (wait_cnt == CNT_SAT) ? wait_cnt : wait_cnt + WAIT_CNT_W'(1);

    // Watchdog: counts WAIT cycles, flags sticky timeout once the limit is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (MAX_WAIT != 0) begin
            wait_cnt <= stay_wait ? cnt_inc : '0;
            if (stay_wait && (cnt_inc == WAIT_LIMIT))
                mem_timeout <= 1'b1;
        end
    end

    // MEM/WB buffer: capture when not stalled, otherwise hold and emit a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb_out <= '0;
            out_valid  <= 1'b0;
        end else if (!mem_stall) begin
            out_valid          <= in_valid;
            mem_wb_out.ctrl_wd <= ex_mem_in.ctrl_wd;
            mem_wb_out.alu_out <= ex_mem_in.alu_out;
            mem_wb_out.cmp_out <= ex_mem_in.cmp_out;
            mem_wb_out.u_imm   <= ex_mem_in.u_imm;
            mem_wb_out.rd      <= ex_mem_in.rd;
            mem_wb_out.mdr     <= mdr_aligned;
`ifdef MEM_STAGE_RVFI_EN
            mem_wb_out.rvfi_d                <= ex_mem_in.rvfi_d;
            mem_wb_out.rvfi_d.rvfi_mem_addr  <= dmem_address;
            mem_wb_out.rvfi_d.rvfi_mem_rmask <= ex_mem_in.ctrl_wd.mem_read
                ? load_rmask(ex_mem_in.ctrl_wd.funct3, off) : 4'b0000;
            mem_wb_out.rvfi_d.rvfi_mem_wmask <= ex_mem_in.ctrl_wd.mem_write
                ? dmem_wmask : 4'b0000;
            mem_wb_out.rvfi_d.rvfi_mem_rdata <= dmem_rdata;
            mem_wb_out.rvfi_d.rvfi_mem_wdata <= dmem_wdata;
`else
            mem_wb_out.rvfi_d  <= ex_mem_in.rvfi_d;
`endif
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a scoreboard of expected MEM/WB words.
module tb_mem_stage;
    import rv32i_types::*;

    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    EX_MEM_stage_t ex_mem_in;
    logic          in_valid;
    logic [31:0]   dmem_address;
    logic          dmem_read;
    logic          dmem_write;
    logic [3:0]    dmem_wmask;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic          dmem_resp;
    logic          mem_stall;
    MEM_WB_stage_t mem_wb_out;
    logic          out_valid;
    logic          mem_timeout;

    MEM_WB_stage_t exp_q[$];
    MEM_WB_stage_t mon_e;
    int            n_chk = 0;
    int            n_err = 0;
    logic          model_to = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(MAX_WAIT), .WAIT_CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem_in    (ex_mem_in),
        .in_valid     (in_valid),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_stall    (mem_stall),
        .mem_wb_out   (mem_wb_out),
        .out_valid    (out_valid),
        .mem_timeout  (mem_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0: begin b = d[7:0];   h = d[15:0];           end
            2'd1: begin b = d[15:8];  h = d[23:8];           end
            2'd2: begin b = d[23:16]; h = d[31:16];          end
            default: begin b = d[31:24]; h = {8'h00, d[31:24]}; end
        endcase
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] model_wmask(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'b010) return 4'b1111;
        if (f3 == 3'b000) begin
            case (off)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        case (off)
            2'd0: return 4'b0011;
            2'd1: return 4'b0110;
            2'd2: return 4'b1100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic EX_MEM_stage_t mk(input logic [2:0] f3, input logic mr, input logic mw,
                                         input logic [31:0] mar, input logic [31:0] alu,
                                         input logic [31:0] wd, input logic [4:0] rd);
        EX_MEM_stage_t e;
        e = '0;
        e.ctrl_wd.funct3    = f3;
        e.ctrl_wd.mem_read  = mr;
        e.ctrl_wd.mem_write = mw;
        e.ctrl_wd.reg_write = !mw;
        e.ctrl_wd.wb_sel    = mr ? 2'd1 : 2'd0;
        e.mar               = mar;
        e.mem_data_out      = wd;
        e.alu_out           = alu;
        e.cmp_out           = alu[0];
        e.u_imm             = {alu[19:0], 12'h000};
        e.rd                = rd;
        e.rvfi_d.pc_rdata   = 32'h0000_1000 + {25'h0, rd, 2'b00};
        e.rvfi_d.insn       = alu ^ mar;
        return e;
    endfunction

    // One instruction through the stage; the cache answers 'delay' cycles after the request.
    task automatic do_op(input EX_MEM_stage_t e, input logic v, input logic [31:0] rdata,
                         input int delay);
        logic          req;
        logic [31:0]   exp_addr;
        MEM_WB_stage_t x;
        req      = v && (e.ctrl_wd.mem_read || e.ctrl_wd.mem_write);
        exp_addr = e.mar & 32'hFFFF_FFFC;
        @(negedge clk);
        ex_mem_in  = e;
        in_valid   = v;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        for (int k = 0; k <= delay; k++) begin
            if (k > 0) @(negedge clk);
            if (k == delay) begin
                dmem_resp  = req;
                dmem_rdata = rdata;
            end
            #1;
            chk("stall", 32'(mem_stall), 32'(req && (k < delay)));
            chk("dmem_read", 32'(dmem_read), 32'(v && e.ctrl_wd.mem_read));
            chk("dmem_write", 32'(dmem_write), 32'(v && e.ctrl_wd.mem_write));
            chk("timeout", 32'(mem_timeout), 32'(model_to || (req && k >= MAX_WAIT + 1)));
            if (req) chk("dmem_addr", dmem_address, exp_addr);
            if (v && e.ctrl_wd.mem_write) begin
                chk("dmem_wmask", 32'(dmem_wmask), 32'(model_wmask(e.ctrl_wd.funct3, e.mar[1:0])));
                chk("dmem_wdata", dmem_wdata, e.mem_data_out);
            end
            if (req && k > 0) chk("wb_bubble", 32'(out_valid), 32'(0));
            if (k == delay && v) begin
                x         = '0;
                x.ctrl_wd = e.ctrl_wd;
                x.alu_out = e.alu_out;
                x.cmp_out = e.cmp_out;
                x.u_imm   = e.u_imm;
                x.rd      = e.rd;
                x.mdr     = model_load(e.ctrl_wd.funct3, e.mar[1:0], dmem_rdata);
                x.rvfi_d  = e.rvfi_d;
`ifdef MEM_STAGE_RVFI_EN
                x.rvfi_d.rvfi_mem_addr = exp_addr;
                x.rvfi_d.rvfi_mem_rmask = !e.ctrl_wd.mem_read ? 4'b0000 :
                    (e.ctrl_wd.funct3 == 3'b010) ? 4'b1111 :
                    (e.ctrl_wd.funct3[0] ? model_wmask(3'b001, e.mar[1:0])
                                         : model_wmask(3'b000, e.mar[1:0]));
                x.rvfi_d.rvfi_mem_wmask = e.ctrl_wd.mem_write
                    ? model_wmask(e.ctrl_wd.funct3, e.mar[1:0]) : 4'b0000;
                x.rvfi_d.rvfi_mem_rdata = dmem_rdata;
                x.rvfi_d.rvfi_mem_wdata = e.mem_data_out;
`endif
                exp_q.push_back(x);
            end
        end
        if (req && delay >= MAX_WAIT + 1) model_to = 1'b1;
    endtask

    // Scoreboard: every valid MEM/WB word must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(out_valid), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_mdr", mem_wb_out.mdr, mon_e.mdr);
                chk("wb_alu", mem_wb_out.alu_out, mon_e.alu_out);
                chk("wb_rd", 32'(mem_wb_out.rd), 32'(mon_e.rd));
                chk("wb_word", 32'(mem_wb_out == mon_e), 32'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        ex_mem_in  = mk(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd1);
        dmem_rdata = 32'h0;
        dmem_resp  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dmem_read", 32'(dmem_read), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_wb_zero", 32'(mem_wb_out == '0), 32'(1));
        chk("rst_timeout", 32'(mem_timeout), 32'(0));
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_op(mk(3'b010, 1'b1, 1'b0, 32'h100, 32'h11, 32'h0, 5'd1), 1'b1, 32'hDEAD_BEEF, 3);
        do_op(mk(3'b000, 1'b1, 1'b0, 32'h203, 32'h22, 32'h0, 5'd2), 1'b1, 32'h8012_3456, 1);
        do_op(mk(3'b100, 1'b1, 1'b0, 32'h203, 32'h33, 32'h0, 5'd3), 1'b1, 32'h8012_3456, 0);
        do_op(mk(3'b001, 1'b1, 1'b0, 32'h202, 32'h44, 32'h0, 5'd4), 1'b1, 32'h8001_1234, 2);
        do_op(mk(3'b101, 1'b1, 1'b0, 32'h201, 32'h55, 32'h0, 5'd5), 1'b1, 32'h00AB_CD00, 0);
        do_op(mk(3'b001, 1'b0, 1'b1, 32'h102, 32'h66, 32'hBEEF_0000, 5'd6), 1'b1, 32'h0, 2);
        do_op(mk(3'b000, 1'b0, 1'b1, 32'h103, 32'h77, 32'hAB00_0000, 5'd7), 1'b1, 32'h0, 1);
        do_op(mk(3'b010, 1'b0, 1'b1, 32'h101, 32'h88, 32'hCAFE_F00D, 5'd8), 1'b1, 32'h0, 0);
        do_op(mk(3'b001, 1'b0, 1'b1, 32'h103, 32'h99, 32'h1234_5678, 5'd9), 1'b1, 32'h0, 0);
        do_op(mk(3'b000, 1'b0, 1'b0, 32'h55, 32'h1234_5678, 32'h0, 5'd10), 1'b1, 32'h0, 0);
        do_op(mk(3'b010, 1'b1, 1'b0, 32'h300, 32'hAA, 32'h0, 5'd11), 1'b0, 32'h0, 0);
        do_op(mk(3'b000, 1'b1, 1'b0, 32'h101, 32'hBB, 32'h0, 5'd12), 1'b1, 32'h0000_7F00, 0);

        // Reset while a load waits: request drops at once, buffer clears.
        @(negedge clk);
        ex_mem_in = mk(3'b010, 1'b1, 1'b0, 32'h300, 32'hCC, 32'h0, 5'd13);
        in_valid  = 1'b1;
        dmem_resp = 1'b0;
        #1;
        chk("abort_stall", 32'(mem_stall), 32'(1));
        @(negedge clk);
        #1;
        chk("abort_read_pre", 32'(dmem_read), 32'(1));
        rst = 1'b1;
        #1;
        chk("abort_read_rst", 32'(dmem_read), 32'(0));
        @(negedge clk);
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_wb_zero", 32'(mem_wb_out == '0), 32'(1));
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("abort_idle_stall", 32'(mem_stall), 32'(0));

        do_op(mk(3'b010, 1'b1, 1'b0, 32'h400, 32'hDD, 32'h0, 5'd14), 1'b1, 32'h0BAD_F00D, 10);
        do_op(mk(3'b100, 1'b1, 1'b0, 32'h402, 32'hEE, 32'h0, 5'd15), 1'b1, 32'h00C3_0000, 1);

        @(negedge clk);
        in_valid  = 1'b0;
        dmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("timeout_sticky", 32'(mem_timeout), 32'(1));
        chk("sb_drain", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
